// File: rtl/div_ctrl_pkg.sv
// Shared constants and state encoding for the multi-cycle DIV/DIVU sequencer.
package div_ctrl_pkg;

    localparam int unsigned RegBus       = 32;
    localparam int unsigned DoubleRegBus = 64;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the 65-bit partial left, trial-subtract the divisor.
module div_step
    import div_ctrl_pkg::*;
(
    input  logic [64:0]       partial_i,
    input  logic [RegBus-1:0] divisor_i,
    output logic [64:0]       partial_o
);

    logic [33:0] diff;

    // Bit 64 of the partial is always zero, so diff[33] is a clean borrow flag.
    always_comb begin
        diff = partial_i[64:31] - {2'b00, divisor_i};
        if (diff[33]) begin
            partial_o = {partial_i[63:0], 1'b0};
        end else begin
            partial_o = {diff[32:0], partial_i[30:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// DIV/DIVU sequencer: 32-step restoring divide, stalls the pipeline while busy,
// returns {remainder, quotient} for the HI/LO write.
module div_ctrl
    import div_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    signed_div_i,
    input  logic [RegBus-1:0]       opdata1_i,
    input  logic [RegBus-1:0]       opdata2_i,
    input  logic                    start_i,
    input  logic                    annul_i,
    output logic [DoubleRegBus-1:0] result_o,
    output logic                    ready_o,
    output logic                    stallreq_o
);

    div_state_e              state_q, state_d;
    logic [5:0]              cnt_q, cnt_d;
    logic [64:0]             partial_q, partial_d;
    logic [RegBus-1:0]       divisor_q, divisor_d;
    logic                    neg_quot_q, neg_quot_d;
    logic                    neg_rem_q, neg_rem_d;
    logic [DoubleRegBus-1:0] result_q, result_d;
    logic                    ready_q, ready_d;

    logic [64:0]       step_out;
    logic              op1_neg, op2_neg;
    logic [RegBus-1:0] op1_abs, op2_abs;
    logic [RegBus-1:0] quot_fix, rem_fix;

    div_step u_div_step (
        .partial_i (partial_q),
        .divisor_i (divisor_q),
        .partial_o (step_out)
    );

    // 0x80000000 negates to itself and is then treated as an unsigned magnitude.
    assign op1_neg  = signed_div_i & opdata1_i[RegBus-1];
    assign op2_neg  = signed_div_i & opdata2_i[RegBus-1];
    assign op1_abs  = op1_neg ? (32'd0 - opdata1_i) : opdata1_i;
    assign op2_abs  = op2_neg ? (32'd0 - opdata2_i) : opdata2_i;
    assign quot_fix = neg_quot_q ? (32'd0 - step_out[31:0]) : step_out[31:0];
    assign rem_fix  = neg_rem_q ? (32'd0 - step_out[63:32]) : step_out[63:32];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        partial_d  = partial_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;
        stallreq_o = 1'b0;

        unique case (state_q)
            DivFree: begin
                result_d = '0;
                ready_d  = DivResultNotReady;
                if (start_i == DivStart && !annul_i) begin
                    stallreq_o = 1'b1;
                    if (opdata2_i == '0) begin
                        state_d = DivByZero;
                    end else begin
                        state_d    = DivOn;
                        cnt_d      = '0;
                        partial_d  = {33'd0, op1_abs};
                        divisor_d  = op2_abs;
                        neg_quot_d = op1_neg ^ op2_neg;
                        neg_rem_d  = op1_neg;
                    end
                end
            end
            DivByZero: begin
                stallreq_o = 1'b1;
                result_d   = '0;
                if (annul_i) begin
                    state_d = DivFree;
                    ready_d = DivResultNotReady;
                end else begin
                    state_d = DivEnd;
                    ready_d = DivResultReady;
                end
            end
            DivOn: begin
                if (annul_i) begin
                    state_d  = DivFree;
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                end else begin
                    stallreq_o = 1'b1;
                    partial_d  = step_out;
                    cnt_d      = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_d  = DivEnd;
                        result_d = {rem_fix, quot_fix};
                        ready_d  = DivResultReady;
                    end
                end
            end
            DivEnd: begin
                if (annul_i || start_i == DivStop) begin
                    state_d  = DivFree;
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                end
            end
            default: state_d = DivFree;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DivFree;
            cnt_q      <= '0;
            partial_q  <= '0;
            divisor_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= DivResultNotReady;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            partial_q  <= partial_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule
